// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-control bundle between the core's decode/execute logic and pc_gen.
// master = core side driving select/operands, slave = pc_gen returning PC and RAS state.
interface pc_gen_if #(
  parameter int DW = 32
);
  logic          stall;
  logic [1:0]    PCsrc;
  logic [DW-1:0] ImmOp;
  logic [DW-1:0] rs1_val;
  logic          is_call;
  logic          is_ret;
  logic [DW-1:0] PCC;
  logic [DW-1:0] pc_plus4;
  logic          misaligned;
  logic [DW-1:0] ras_top;
  logic          ras_valid;

  modport master (
    output stall, PCsrc, ImmOp, rs1_val, is_call, is_ret,
    input  PCC, pc_plus4, misaligned, ras_top, ras_valid
  );

  modport slave (
    input  stall, PCsrc, ImmOp, rs1_val, is_call, is_ret,
    output PCC, pc_plus4, misaligned, ras_top, ras_valid
  );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: next-PC selection (seq/branch/jalr/trap) with misaligned-target redirect and stall.
// Optional return-address stack is built when the PC_RAS_EN macro is defined.
module pc_gen #(
  parameter int            DW        = 32,
  parameter logic [DW-1:0] RESET_VEC = {DW{1'b0}},
  parameter logic [DW-1:0] TRAP_VEC  = DW'(32'h0000_0100),
  parameter int            RAS_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  pc_gen_if.slave  bus
);
  localparam logic [DW-1:0] C_FOUR = DW'(3'd4);

  logic [DW-1:0] r_pc;
  logic          r_mis;
  logic [DW-1:0] w_pc_plus4;
  logic [DW-1:0] w_jalr_sum;
  logic [DW-1:0] w_cand;
  logic [DW-1:0] w_next;
  logic          w_chk;
  logic          w_mis;

  assign w_pc_plus4 = r_pc + C_FOUR;
  assign w_jalr_sum = bus.rs1_val + bus.ImmOp;

  // Only computed targets (branch, jalr) can be misaligned; those redirect to the trap vector.
  always_comb begin
    w_cand = w_pc_plus4;
    w_chk  = 1'b0;
    case (bus.PCsrc)
      2'd0: begin w_cand = w_pc_plus4;                    w_chk = 1'b0; end
      2'd1: begin w_cand = r_pc + bus.ImmOp;              w_chk = 1'b1; end
      2'd2: begin w_cand = {w_jalr_sum[DW-1:1], 1'b0};    w_chk = 1'b1; end
      2'd3: begin w_cand = TRAP_VEC;                      w_chk = 1'b0; end
      default: begin w_cand = w_pc_plus4;                 w_chk = 1'b0; end
    endcase
    w_mis = w_chk & (w_cand[1:0] != 2'b00);
    if (w_mis) begin
      w_next = TRAP_VEC;
    end else begin
      w_next = w_cand;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc  <= RESET_VEC;
      r_mis <= 1'b0;
    end else if (bus.stall) begin
      r_pc  <= r_pc;
      r_mis <= 1'b0;
    end else begin
      r_pc  <= w_next;
      r_mis <= w_mis;
    end
  end

  assign bus.PCC        = r_pc;
  assign bus.pc_plus4   = w_pc_plus4;
  assign bus.misaligned = r_mis;

`ifdef PC_RAS_EN
  localparam int         PW     = $clog2(RAS_DEPTH);
  localparam logic [PW:0] C_FULL = (PW+1)'(RAS_DEPTH);

  logic [DW-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0] r_ptr;
  logic [PW:0]   r_cnt;
  logic [PW-1:0] w_ptr_nxt;
  logic [PW:0]   w_cnt_nxt;
  logic [PW-1:0] w_wr_idx;
  logic          w_wr_en;

  // call+ret on a non-empty stack replaces the top; on an empty stack it falls through to a push.
  always_comb begin
    w_ptr_nxt = r_ptr;
    w_cnt_nxt = r_cnt;
    w_wr_en   = 1'b0;
    w_wr_idx  = r_ptr;
    if (bus.is_call && bus.is_ret && (r_cnt != {(PW+1){1'b0}})) begin
      w_wr_en  = 1'b1;
      w_wr_idx = r_ptr;
    end else if (bus.is_call) begin
      w_wr_en   = 1'b1;
      w_wr_idx  = r_ptr + PW'(1'b1);
      w_ptr_nxt = r_ptr + PW'(1'b1);
      if (r_cnt != C_FULL) begin
        w_cnt_nxt = r_cnt + (PW+1)'(1'b1);
      end else begin
        w_cnt_nxt = r_cnt;
      end
    end else if (bus.is_ret && (r_cnt != {(PW+1){1'b0}})) begin
      w_ptr_nxt = r_ptr - PW'(1'b1);
      w_cnt_nxt = r_cnt - (PW+1)'(1'b1);
    end else begin
      w_ptr_nxt = r_ptr;
      w_cnt_nxt = r_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= {PW{1'b0}};
      r_cnt <= {(PW+1){1'b0}};
    end else if (!bus.stall) begin
      r_ptr <= w_ptr_nxt;
      r_cnt <= w_cnt_nxt;
    end else begin
      r_ptr <= r_ptr;
      r_cnt <= r_cnt;
    end
  end

  // Storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (!rst && !bus.stall && w_wr_en) begin
      r_ras[w_wr_idx] <= w_pc_plus4;
    end
  end

  assign bus.ras_valid = (r_cnt != {(PW+1){1'b0}});
  assign bus.ras_top   = bus.ras_valid ? r_ras[r_ptr] : {DW{1'b0}};
`else
  logic w_unused;
  assign w_unused      = ^{bus.is_call, bus.is_ret, RAS_DEPTH[0]};
  assign bus.ras_valid = 1'b0;
  assign bus.ras_top   = {DW{1'b0}};
`endif
endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: a reference model pushes expected state per driven cycle,
// each test task pops and compares after the edge. RAS expectations follow PC_RAS_EN.
module tb_pc_gen;
  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;
  localparam int          D         = 4;
`ifdef PC_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic        mis;
    logic        rv;
    logic [31:0] rt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_gen_if #(.DW(32)) bus ();

  pc_gen #(.DW(32), .RESET_VEC(RESET_VEC), .TRAP_VEC(TRAP_VEC), .RAS_DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        sb[$];
  exp_t        e;
  int          n_vec = 0;
  int          n_mis = 0;
  logic [31:0] m_pc;
  logic        m_mis;
  logic [31:0] m_ras [D];
  int          m_ptr;
  int          m_cnt;

  // Drive one cycle of stimulus, advance the model, queue the expectation, clock once.
  task automatic apply(input logic r, input logic st, input logic [1:0] src,
                       input logic [31:0] imm, input logic [31:0] rs1,
                       input logic call, input logic ret);
    logic [31:0] p4, cand;
    logic        chk;
    exp_t        x;
    rst = r; bus.stall = st; bus.PCsrc = src; bus.ImmOp = imm;
    bus.rs1_val = rs1; bus.is_call = call; bus.is_ret = ret;
    p4 = m_pc + 32'd4;
    if (r) begin
      m_pc = RESET_VEC; m_mis = 1'b0; m_ptr = 0; m_cnt = 0;
    end else if (st) begin
      m_mis = 1'b0;
    end else begin
      if (RAS_ON) begin
        if (call && ret && m_cnt > 0) m_ras[m_ptr] = p4;
        else if (call) begin
          m_ptr = (m_ptr + 1) % D; m_ras[m_ptr] = p4;
          if (m_cnt < D) m_cnt = m_cnt + 1;
        end else if (ret && m_cnt > 0) begin
          m_ptr = (m_ptr + D - 1) % D; m_cnt = m_cnt - 1;
        end
      end
      chk = 1'b0;
      case (src)
        2'd0: cand = p4;
        2'd1: begin cand = m_pc + imm; chk = 1'b1; end
        2'd2: begin cand = (rs1 + imm) & 32'hFFFF_FFFE; chk = 1'b1; end
        default: cand = TRAP_VEC;
      endcase
      m_mis = chk && (cand[1:0] != 2'b00);
      m_pc  = m_mis ? TRAP_VEC : cand;
    end
    x.pc = m_pc; x.mis = m_mis; x.rv = (m_cnt != 0);
    x.rt = x.rv ? m_ras[m_ptr] : 32'h0;
    sb.push_back(x);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      e = sb.pop_front();
      n_vec++; if (bus.PCC !== e.pc) begin n_mis++; $display("FAIL reset_pc: got %h want %h", bus.PCC, e.pc); end
      n_vec++; if (bus.misaligned !== e.mis) begin n_mis++; $display("FAIL reset_mis: got %b want %b", bus.misaligned, e.mis); end
      n_vec++; if (bus.ras_valid !== e.rv) begin n_mis++; $display("FAIL reset_rv: got %b want %b", bus.ras_valid, e.rv); end
      n_vec++; if (bus.ras_top !== e.rt) begin n_mis++; $display("FAIL reset_rt: got %h want %h", bus.ras_top, e.rt); end
      n_vec++; if (bus.pc_plus4 !== e.pc + 32'd4) begin n_mis++; $display("FAIL reset_p4: got %h want %h", bus.pc_plus4, e.pc + 32'd4); end
    end
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      e = sb.pop_front();
      n_vec++; if (bus.PCC !== e.pc) begin n_mis++; $display("FAIL seq_pc: got %h want %h", bus.PCC, e.pc); end
      n_vec++; if (bus.misaligned !== e.mis) begin n_mis++; $display("FAIL seq_mis: got %b want %b", bus.misaligned, e.mis); end
    end
  endtask

  task automatic test_branch_jalr();
    logic [1:0]  src [7] = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1};
    logic [31:0] imm [7] = '{32'h0, 32'h20, 32'h0, 32'h2, 32'h0, 32'h0, 32'hFFFF_FFF0};
    logic [31:0] rs1 [7] = '{32'h0, 32'h0, 32'h101, 32'h0, 32'h0, 32'h102, 32'h0};
    for (int i = 0; i < 7; i++) begin
      apply(1'b0, 1'b0, src[i], imm[i], rs1[i], 1'b0, 1'b0);
      e = sb.pop_front();
      n_vec++; if (bus.PCC !== e.pc) begin n_mis++; $display("FAIL br_pc[%0d]: got %h want %h", i, bus.PCC, e.pc); end
      n_vec++; if (bus.misaligned !== e.mis) begin n_mis++; $display("FAIL br_mis[%0d]: got %b want %b", i, bus.misaligned, e.mis); end
    end
  endtask

  task automatic test_wrap();
    apply(1'b0, 1'b0, 2'd2, 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b0);
    e = sb.pop_front();
    n_vec++; if (bus.pc_plus4 !== e.pc + 32'd4) begin n_mis++; $display("FAIL wrap_p4: got %h want %h", bus.pc_plus4, e.pc + 32'd4); end
    apply(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    e = sb.pop_front();
    n_vec++; if (bus.PCC !== e.pc) begin n_mis++; $display("FAIL wrap_pc: got %h want %h", bus.PCC, e.pc); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, (i < 2), 2'd3, 32'h0, 32'h0, (i < 2), 1'b0);
      e = sb.pop_front();
      n_vec++; if (bus.PCC !== e.pc) begin n_mis++; $display("FAIL stall_pc[%0d]: got %h want %h", i, bus.PCC, e.pc); end
      n_vec++; if (bus.misaligned !== e.mis) begin n_mis++; $display("FAIL stall_mis[%0d]: got %b want %b", i, bus.misaligned, e.mis); end
      n_vec++; if (bus.ras_valid !== e.rv) begin n_mis++; $display("FAIL stall_rv[%0d]: got %b want %b", i, bus.ras_valid, e.rv); end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, (i == 2), 2'd1, 32'h2, 32'h0, 1'b0, 1'b0);
      e = sb.pop_front();
      n_vec++; if (bus.PCC !== e.pc) begin n_mis++; $display("FAIL b2b_pc[%0d]: got %h want %h", i, bus.PCC, e.pc); end
      n_vec++; if (bus.misaligned !== e.mis) begin n_mis++; $display("FAIL b2b_mis[%0d]: got %b want %b", i, bus.misaligned, e.mis); end
    end
  endtask

  task automatic test_ras();
    apply(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    void'(sb.pop_front());
    // Five calls overflow a depth-4 stack, then five returns drain it and underflow once.
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, (i < 5), (i >= 5));
      e = sb.pop_front();
      n_vec++; if (bus.ras_top !== e.rt) begin n_mis++; $display("FAIL ras_top[%0d]: got %h want %h", i, bus.ras_top, e.rt); end
      n_vec++; if (bus.ras_valid !== e.rv) begin n_mis++; $display("FAIL ras_rv[%0d]: got %b want %b", i, bus.ras_valid, e.rv); end
    end
    apply(1'b0, 1'b0, 2'd2, 32'h0, 32'h20, 1'b0, 1'b0);
    void'(sb.pop_front());
    apply(1'b0, 1'b0, 2'd2, 32'h0, 32'h40, 1'b1, 1'b0);
    void'(sb.pop_front());
    apply(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b1);
    e = sb.pop_front();
    n_vec++; if (bus.ras_top !== e.rt) begin n_mis++; $display("FAIL callret_top: got %h want %h", bus.ras_top, e.rt); end
    n_vec++; if (bus.ras_valid !== e.rv) begin n_mis++; $display("FAIL callret_rv: got %b want %b", bus.ras_valid, e.rv); end
    n_vec++; if (bus.PCC !== e.pc) begin n_mis++; $display("FAIL callret_pc: got %h want %h", bus.PCC, e.pc); end
    apply(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    void'(sb.pop_front());
    apply(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b1);
    e = sb.pop_front();
    n_vec++; if (bus.ras_top !== e.rt) begin n_mis++; $display("FAIL callret_empty_top: got %h want %h", bus.ras_top, e.rt); end
    n_vec++; if (bus.ras_valid !== e.rv) begin n_mis++; $display("FAIL callret_empty_rv: got %b want %b", bus.ras_valid, e.rv); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b0);
      e = sb.pop_front();
      n_vec++; if (bus.ras_valid !== e.rv) begin n_mis++; $display("FAIL mid_push_rv[%0d]: got %b want %b", i, bus.ras_valid, e.rv); end
    end
    apply(1'b1, 1'b1, 2'd3, 32'h0, 32'h0, 1'b1, 1'b1);
    e = sb.pop_front();
    n_vec++; if (bus.PCC !== e.pc) begin n_mis++; $display("FAIL mid_rst_pc: got %h want %h", bus.PCC, e.pc); end
    n_vec++; if (bus.ras_valid !== e.rv) begin n_mis++; $display("FAIL mid_rst_rv: got %b want %b", bus.ras_valid, e.rv); end
    n_vec++; if (bus.ras_top !== e.rt) begin n_mis++; $display("FAIL mid_rst_rt: got %h want %h", bus.ras_top, e.rt); end
  endtask

  initial begin
    rst = 1'b1; bus.stall = 1'b0; bus.PCsrc = 2'd0; bus.ImmOp = 32'h0;
    bus.rs1_val = 32'h0; bus.is_call = 1'b0; bus.is_ret = 1'b0;
    m_pc = RESET_VEC; m_mis = 1'b0; m_ptr = 0; m_cnt = 0;
    for (int i = 0; i < D; i++) m_ras[i] = 32'h0;
    test_reset();
    test_branch_jalr();
    test_wrap();
    test_stall();
    test_back_to_back();
    test_ras();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
